// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the fetch unit and the PIPE core:
// instruction codes, status codes and the instruction-length helper.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } fetch_state_t;

  // Undefined icodes report length 1 so only the opcode byte counts toward the ADR check.
  function automatic logic [3:0] y86_ilen(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:  y86_ilen = 4'd2;
      I_JXX, I_CALL:                     y86_ilen = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      y86_ilen = 4'd10;
      default:                           y86_ilen = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_split.sv
// Combinational splitter: turns a 10-byte little-endian window (byte 0 at
// bits 7:0) into Y86-64 instruction fields, length and an ifun/icode legality flag.
module y86_instr_split
  import y86_pkg::*;
(
  input  logic [79:0] win,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valc,
  output logic [3:0]  ilen,
  output logic        ins_ok
);

  logic has_regs;

  always_comb begin
    icode    = win[7:4];
    ifun     = win[3:0];
    ilen     = y86_ilen(win[7:4]);
    has_regs = 1'b0;
    valc     = 64'd0;
    ins_ok   = 1'b0;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: has_regs = 1'b1;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        has_regs = 1'b1;
        valc     = win[79:16];
      end
      I_JXX, I_CALL: valc = win[71:8];
      default: ;
    endcase
    case (icode)
      I_RRMOVQ, I_JXX: ins_ok = (ifun <= 4'd6);
      I_OPQ:           ins_ok = (ifun <= 4'd3);
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_CALL, I_RET, I_PUSHQ, I_POPQ: ins_ok = (ifun == 4'd0);
      default:         ins_ok = 1'b0;
    endcase
    ra = has_regs ? win[15:12] : REG_NONE;
    rb = has_regs ? win[11:8]  : REG_NONE;
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch stage: byte-loaded instruction memory, registered PC, one-cycle
// registered f_* outputs, and a sticky RUN/HALTED/FAULT status machine.
//
// state    | meaning
// S_RUN    | fetching; each unstalled cycle emits one instruction
// S_HALTED | halt emitted; outputs frozen with f_valid=0 until reset
// S_FAULT  | ADR/INS emitted; outputs frozen with f_valid=0 until reset
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'd0,
  localparam int         AW         = $clog2(IMEM_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          stall,
  input  logic          redirect,
  input  logic [63:0]   redirect_pc,
  output logic          f_valid,
  output logic [63:0]   f_pc,
  output logic [3:0]    f_icode,
  output logic [3:0]    f_ifun,
  output logic [3:0]    f_rA,
  output logic [3:0]    f_rB,
  output logic [63:0]   f_valC,
  output logic [63:0]   f_valP,
  output logic [2:0]    f_stat
);

  logic [7:0]   mem [IMEM_BYTES];
  logic [63:0]  pc_q;
  logic [79:0]  win;
  logic [63:0]  byte_addr;
  logic [3:0]   icode, ifun, ra, rb, ilen;
  logic [63:0]  valc, valp, end_addr;
  logic         ins_ok, adr;
  logic [2:0]   fetch_stat;
  fetch_state_t state_q, state_d;
  logic         fetch_en, idle;

  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
  end

  // Out-of-range window bytes read as zero, so the array is never indexed past its end.
  always_comb begin
    win       = 80'd0;
    byte_addr = 64'd0;
    for (int i = 0; i < 10; i++) begin
      byte_addr = pc_q + 64'(i);
      if (byte_addr < 64'(IMEM_BYTES)) win[i*8 +: 8] = mem[byte_addr[AW-1:0]];
    end
  end

  y86_instr_split u_split (
    .win    (win),
    .icode  (icode),
    .ifun   (ifun),
    .ra     (ra),
    .rb     (rb),
    .valc   (valc),
    .ilen   (ilen),
    .ins_ok (ins_ok)
  );

  // A PC already past the end (including a wrapped one) is caught by the first term.
  always_comb begin
    valp     = pc_q + 64'(ilen);
    end_addr = valp - 64'd1;
    adr      = (pc_q >= 64'(IMEM_BYTES)) || (end_addr >= 64'(IMEM_BYTES));
    if (adr)                 fetch_stat = STAT_ADR;
    else if (!ins_ok)        fetch_stat = STAT_INS;
    else if (icode == I_HALT) fetch_stat = STAT_HLT;
    else                     fetch_stat = STAT_AOK;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_RUN && !stall) begin
      if (fetch_stat == STAT_ADR || fetch_stat == STAT_INS) state_d = S_FAULT;
      else if (fetch_stat == STAT_HLT)                      state_d = S_HALTED;
    end
  end

  always_comb begin
    fetch_en = (state_q == S_RUN) && !stall;
    idle     = (state_q != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      f_valid <= 1'b0;
      f_pc    <= 64'd0;
      f_icode <= 4'd0;
      f_ifun  <= 4'd0;
      f_rA    <= 4'd0;
      f_rB    <= 4'd0;
      f_valC  <= 64'd0;
      f_valP  <= 64'd0;
      f_stat  <= STAT_AOK;
    end else if (fetch_en) begin
      f_valid <= 1'b1;
      f_pc    <= pc_q;
      f_icode <= icode;
      f_ifun  <= ifun;
      f_rA    <= ra;
      f_rB    <= rb;
      f_valC  <= adr ? 64'd0 : valc;
      f_valP  <= adr ? 64'd0 : valp;
      f_stat  <= fetch_stat;
      if (fetch_stat == STAT_AOK) pc_q <= redirect ? redirect_pc : valp;
    end else if (idle) begin
      f_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed self-checking bench for y86_fetch_unit with hand-computed expectations.
module tb_y86_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_we = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        f_valid;
  logic [63:0] f_pc, f_valC, f_valP;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [2:0]  f_stat;

  int n_chk = 0;
  int n_fail = 0;

  y86_fetch_unit #(.IMEM_BYTES(1024), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .f_valid(f_valid), .f_pc(f_pc), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic enter_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
  endtask

  task automatic test_reset();
    enter_reset();
    n_chk++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0d want 0", f_valid); end
    n_chk++; if (f_stat !== 3'd1) begin n_fail++; $display("FAIL reset_stat got %0d want 1", f_stat); end
    n_chk++; if (f_pc !== 64'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", f_pc); end
    n_chk++; if (f_valP !== 64'd0 || f_icode !== 4'd0) begin n_fail++; $display("FAIL reset_fields got valP=%h icode=%h want 0", f_valP, f_icode); end
  endtask

  task automatic test_irmovq();
    enter_reset();
    load(10'd0, 8'h30); load(10'd1, 8'hF2);
    for (int i = 2; i < 10; i++) load(10'(i), 8'h00);
    load(10'd10, 8'h10);
    reset = 1'b0;
    tick();
    n_chk++; if (f_valid !== 1'b1) begin n_fail++; $display("FAIL irmov_valid got %0d want 1", f_valid); end
    n_chk++; if (f_icode !== 4'h3 || f_ifun !== 4'h0) begin n_fail++; $display("FAIL irmov_code got %h/%h want 3/0", f_icode, f_ifun); end
    n_chk++; if (f_rA !== 4'hF || f_rB !== 4'h2) begin n_fail++; $display("FAIL irmov_regs got %h/%h want F/2", f_rA, f_rB); end
    n_chk++; if (f_valC !== 64'd0 || f_valP !== 64'd10) begin n_fail++; $display("FAIL irmov_vals got valC=%h valP=%h want 0/a", f_valC, f_valP); end
    n_chk++; if (f_stat !== 3'd1) begin n_fail++; $display("FAIL irmov_stat got %0d want 1", f_stat); end
    tick();
    n_chk++; if (f_pc !== 64'd10 || f_icode !== 4'h1) begin n_fail++; $display("FAIL irmov_next got pc=%h icode=%h want a/1", f_pc, f_icode); end
  endtask

  task automatic test_nop_addq_halt();
    enter_reset();
    load(10'd0, 8'h10); load(10'd1, 8'h60); load(10'd2, 8'h01); load(10'd3, 8'h00);
    reset = 1'b0;
    tick();
    n_chk++; if (f_icode !== 4'h1 || f_valP !== 64'd1 || f_rA !== 4'hF) begin n_fail++; $display("FAIL nop got icode=%h valP=%h rA=%h want 1/1/F", f_icode, f_valP, f_rA); end
    tick();
    n_chk++; if (f_pc !== 64'd1 || f_icode !== 4'h6 || f_rA !== 4'h0 || f_rB !== 4'h1 || f_valP !== 64'd3)
      begin n_fail++; $display("FAIL addq got pc=%h icode=%h rA=%h rB=%h valP=%h want 1/6/0/1/3", f_pc, f_icode, f_rA, f_rB, f_valP); end
    tick();
    n_chk++; if (f_valid !== 1'b1 || f_stat !== 3'd2 || f_pc !== 64'd3 || f_valP !== 64'd4)
      begin n_fail++; $display("FAIL halt got valid=%0d stat=%0d pc=%h valP=%h want 1/2/3/4", f_valid, f_stat, f_pc, f_valP); end
    for (int i = 0; i < 20; i++) begin
      redirect = (i == 5); redirect_pc = 64'h40; stall = (i == 8);
      tick();
      n_chk++; if (f_valid !== 1'b0 || f_pc !== 64'd3 || f_stat !== 3'd2)
        begin n_fail++; $display("FAIL halted_hold[%0d] got valid=%0d pc=%h stat=%0d want 0/3/2", i, f_valid, f_pc, f_stat); end
    end
    redirect = 1'b0; stall = 1'b0;
  endtask

  task automatic test_redirect_stall();
    enter_reset();
    load(10'd0, 8'h70); load(10'd1, 8'h40);
    for (int i = 2; i < 9; i++) load(10'(i), 8'h00);
    load(10'h40, 8'h10); load(10'h41, 8'h10); load(10'h42, 8'h10); load(10'h80, 8'h00);
    reset = 1'b0; redirect = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect = 1'b0;
    n_chk++; if (f_icode !== 4'h7 || f_valP !== 64'd9 || f_valC !== 64'h40)
      begin n_fail++; $display("FAIL jxx got icode=%h valP=%h valC=%h want 7/9/40", f_icode, f_valP, f_valC); end
    tick();
    n_chk++; if (f_pc !== 64'h40 || f_icode !== 4'h1) begin n_fail++; $display("FAIL redirect_target got pc=%h icode=%h want 40/1", f_pc, f_icode); end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (f_valid !== 1'b1 || f_pc !== 64'h40 || f_valP !== 64'h41 || f_icode !== 4'h1)
        begin n_fail++; $display("FAIL stall_hold[%0d] got valid=%0d pc=%h valP=%h want 1/40/41", i, f_valid, f_pc, f_valP); end
    end
    stall = 1'b0; redirect = 1'b0;
    tick();
    n_chk++; if (f_pc !== 64'h41 || f_stat !== 3'd1) begin n_fail++; $display("FAIL after_stall got pc=%h stat=%0d want 41/1", f_pc, f_stat); end
  endtask

  task automatic test_adr();
    enter_reset();
    load(10'd0, 8'h10);
    load(10'd1019, 8'h30); load(10'd1020, 8'hF2);
    reset = 1'b0; redirect = 1'b1; redirect_pc = 64'd1019;
    tick();
    redirect = 1'b0;
    tick();
    n_chk++; if (f_valid !== 1'b1 || f_stat !== 3'd3 || f_pc !== 64'd1019 || f_icode !== 4'h3)
      begin n_fail++; $display("FAIL adr got valid=%0d stat=%0d pc=%h icode=%h want 1/3/3fb/3", f_valid, f_stat, f_pc, f_icode); end
    n_chk++; if (f_valC !== 64'd0 || f_valP !== 64'd0) begin n_fail++; $display("FAIL adr_vals got valC=%h valP=%h want 0/0", f_valC, f_valP); end
    tick(); tick();
    n_chk++; if (f_valid !== 1'b0 || f_stat !== 3'd3 || f_pc !== 64'd1019)
      begin n_fail++; $display("FAIL fault_hold got valid=%0d stat=%0d pc=%h want 0/3/3fb", f_valid, f_stat, f_pc); end
    // exact fit at the top of memory, then run off the end
    enter_reset();
    load(10'd0, 8'h10);
    load(10'd1014, 8'h30); load(10'd1015, 8'hF3); load(10'd1016, 8'h88);
    for (int i = 1017; i < 1024; i++) load(10'(i), 8'h00);
    reset = 1'b0; redirect = 1'b1; redirect_pc = 64'd1014;
    tick();
    redirect = 1'b0;
    tick();
    n_chk++; if (f_stat !== 3'd1 || f_valC !== 64'h88 || f_valP !== 64'd1024 || f_rB !== 4'h3)
      begin n_fail++; $display("FAIL edge_fit got stat=%0d valC=%h valP=%h rB=%h want 1/88/400/3", f_stat, f_valC, f_valP, f_rB); end
    tick();
    n_chk++; if (f_stat !== 3'd3 || f_pc !== 64'd1024 || f_valid !== 1'b1)
      begin n_fail++; $display("FAIL past_end got stat=%0d pc=%h valid=%0d want 3/400/1", f_stat, f_pc, f_valid); end
    enter_reset();
    reset = 1'b0; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect = 1'b0;
    tick();
    n_chk++; if (f_stat !== 3'd3 || f_pc !== 64'hFFFF_FFFF_FFFF_FFFF)
      begin n_fail++; $display("FAIL wrap_pc got stat=%0d pc=%h want 3/ffffffffffffffff", f_stat, f_pc); end
  endtask

  task automatic test_ins();
    enter_reset(); load(10'd0, 8'hC0); reset = 1'b0;
    tick();
    n_chk++; if (f_stat !== 3'd4 || f_icode !== 4'hC || f_valid !== 1'b1 || f_valP !== 64'd1)
      begin n_fail++; $display("FAIL ins_c0 got stat=%0d icode=%h valid=%0d valP=%h want 4/C/1/1", f_stat, f_icode, f_valid, f_valP); end
    tick();
    n_chk++; if (f_valid !== 1'b0 || f_stat !== 3'd4) begin n_fail++; $display("FAIL ins_hold got valid=%0d stat=%0d want 0/4", f_valid, f_stat); end
    enter_reset(); load(10'd0, 8'h27); load(10'd1, 8'h12); reset = 1'b0;
    tick();
    n_chk++; if (f_stat !== 3'd4 || f_icode !== 4'h2 || f_ifun !== 4'h7)
      begin n_fail++; $display("FAIL ins_27 got stat=%0d icode=%h ifun=%h want 4/2/7", f_stat, f_icode, f_ifun); end
    enter_reset(); load(10'd0, 8'h26); load(10'd1, 8'h12); load(10'd2, 8'h10); reset = 1'b0;
    tick();
    n_chk++; if (f_stat !== 3'd1 || f_ifun !== 4'h6 || f_rA !== 4'h1 || f_rB !== 4'h2 || f_valP !== 64'd2)
      begin n_fail++; $display("FAIL cmov_26 got stat=%0d ifun=%h rA=%h rB=%h valP=%h want 1/6/1/2/2", f_stat, f_ifun, f_rA, f_rB, f_valP); end
    enter_reset(); load(10'd0, 8'h64); reset = 1'b0;
    tick();
    n_chk++; if (f_stat !== 3'd4) begin n_fail++; $display("FAIL ins_64 got stat=%0d want 4", f_stat); end
  endtask

  task automatic test_reset_midrun();
    enter_reset();
    for (int i = 0; i < 6; i++) load(10'(i), 8'h10);
    reset = 1'b0;
    tick(); tick(); tick();
    n_chk++; if (f_pc !== 64'd2) begin n_fail++; $display("FAIL midrun_pc got %h want 2", f_pc); end
    reset = 1'b1;
    tick();
    n_chk++; if (f_valid !== 1'b0 || f_stat !== 3'd1 || f_pc !== 64'd0)
      begin n_fail++; $display("FAIL midrun_reset got valid=%0d stat=%0d pc=%h want 0/1/0", f_valid, f_stat, f_pc); end
    reset = 1'b0;
    tick();
    n_chk++; if (f_valid !== 1'b1 || f_pc !== 64'd0 || f_icode !== 4'h1)
      begin n_fail++; $display("FAIL midrun_resume got valid=%0d pc=%h icode=%h want 1/0/1", f_valid, f_pc, f_icode); end
    // reset out of HALTED
    enter_reset(); load(10'd0, 8'h00); reset = 1'b0;
    tick(); tick();
    n_chk++; if (f_valid !== 1'b0 || f_stat !== 3'd2) begin n_fail++; $display("FAIL pre_halt_reset got valid=%0d stat=%0d want 0/2", f_valid, f_stat); end
    reset = 1'b1;
    tick();
    n_chk++; if (f_valid !== 1'b0 || f_stat !== 3'd1) begin n_fail++; $display("FAIL halt_reset got valid=%0d stat=%0d want 0/1", f_valid, f_stat); end
    load(10'd0, 8'h10);
    reset = 1'b0;
    tick();
    n_chk++; if (f_valid !== 1'b1 || f_icode !== 4'h1 || f_stat !== 3'd1)
      begin n_fail++; $display("FAIL halt_resume got valid=%0d icode=%h stat=%0d want 1/1/1", f_valid, f_icode, f_stat); end
  endtask

  task automatic test_loader_collision();
    enter_reset();
    for (int i = 0; i < 4; i++) load(10'(i), 8'h10);
    reset = 1'b0;
    ld_we = 1'b1; ld_addr = 10'd0; ld_data = 8'h00;
    tick();
    ld_we = 1'b0;
    n_chk++; if (f_icode !== 4'h1 || f_stat !== 3'd1) begin n_fail++; $display("FAIL ld_collide got icode=%h stat=%0d want 1/1", f_icode, f_stat); end
    enter_reset(); reset = 1'b0;
    tick();
    n_chk++; if (f_icode !== 4'h0 || f_stat !== 3'd2) begin n_fail++; $display("FAIL ld_written got icode=%h stat=%0d want 0/2", f_icode, f_stat); end
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_nop_addq_halt();
    test_redirect_stall();
    test_adr();
    test_ins();
    test_reset_midrun();
    test_loader_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
